// File: rtl/ddr_pkg.sv
// ddr_pkg: shared types and constants for the arrow step sequencer.
//   seq_state_t : sequencer FSM states (IDLE, PLAY, FLUSH, DONE)
//   COL_RESET   : column select value after reset
//   LEFT/DOWN/UP/RIGHT : bit positions of each arrow inside a 4-bit step
package ddr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam logic [3:0] COL_RESET = 4'b0001;

    localparam int LEFT  = 3;
    localparam int DOWN  = 2;
    localparam int UP    = 1;
    localparam int RIGHT = 0;

endpackage

// File: rtl/step_sequencer_if.sv
// step_sequencer_if: control and output bundle of the step sequencer.
//   start, pause        : level controls from the game logic
//   stepEn, inputStep   : beat strobe and the step bits that go with it
//   colEn               : one-hot arrow column select
//   stepCount           : song steps issued since the last start
//   playing, songDone   : status flags
//   state               : FSM state, exported for debug and checkers
//
// Handshake: stepEn is a one-cycle valid strobe with no ready. The consumer
// must capture inputStep in every cycle where stepEn is high; there is no
// back-pressure, so a missed strobe is a lost step.
interface step_sequencer_if #(
    parameter int SONG_LEN = 64
);
    import ddr_pkg::*;

    localparam int CW = $clog2(SONG_LEN + 1);

    logic          start;
    logic          pause;
    logic          stepEn;
    logic [3:0]    inputStep;
    logic [3:0]    colEn;
    logic [CW-1:0] stepCount;
    logic          playing;
    logic          songDone;
    seq_state_t    state;

    modport master (
        output start, pause,
        input  stepEn, inputStep, colEn, stepCount, playing, songDone, state
    );

    modport slave (
        input  start, pause,
        output stepEn, inputStep, colEn, stepCount, playing, songDone, state
    );

endinterface

// File: rtl/step_rom.sv
// step_rom: song pattern ROM, SONG_LEN words of 4 bits, synchronous read.
//   clk  : clock
//   addr : word address; addresses at or beyond SONG_LEN read as 0
//   data : registered word, valid the cycle after addr is presented
// Contents come from SONG_INIT, word i in bits [4*i+3 : 4*i].
module step_rom #(
    parameter int                    SONG_LEN  = 64,
    parameter int                    AW        = 7,
    parameter logic [4*SONG_LEN-1:0] SONG_INIT = '0
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [3:0]    data
);

    always_ff @(posedge clk) begin
        if (int'(addr) < SONG_LEN) begin
            data <= SONG_INIT[4*int'(addr) +: 4];
        end else begin
            data <= 4'b0000;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: plays the song ROM one step per beat, then issues blank
// flush beats so every note scrolls off the display, and rotates the
// one-hot column select for the LED arrow matrix.
//   clk, reset : clock, synchronous active-high reset
//   bus        : step_sequencer_if slave (start/pause in, step stream and
//                status out)
module step_sequencer
    import ddr_pkg::*;
#(
    parameter int                    BEAT_CYCLES = 1_000_000,
    parameter int                    SCAN_CYCLES = 1000,
    parameter int                    SONG_LEN    = 64,
    parameter int                    FLUSH_BEATS = 8,
    parameter logic [4*SONG_LEN-1:0] SONG_INIT   = '0
) (
    input  logic            clk,
    input  logic            reset,
    step_sequencer_if.slave bus
);

    localparam int BW = $clog2(BEAT_CYCLES);
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CW = $clog2(SONG_LEN + 1);
    localparam int FW = $clog2(FLUSH_BEATS + 1);

    localparam logic [BW-1:0] BEAT_LAST  = BW'(BEAT_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] SONG_LAST  = CW'(SONG_LEN - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_BEATS - 1);

    seq_state_t    state, state_next;
    logic [BW-1:0] beat_cnt;
    logic [SW-1:0] scan_cnt;
    logic [3:0]    col_en;
    logic [CW-1:0] step_count;
    logic [CW-1:0] step_addr_next;
    logic [FW-1:0] flush_cnt;
    logic [3:0]    rom_data;
    logic          active;
    logic          beat_tick;
    logic          start_go;

    assign active   = (state == PLAY) || (state == FLUSH);
    // Pause wins over terminal count; reset also masks the strobe so no
    // pulse escapes in the cycle reset is applied.
    assign beat_tick = active && !bus.pause && !reset && (beat_cnt == BEAT_LAST);
    assign start_go  = ((state == IDLE) || (state == DONE)) && bus.start;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.start) state_next = PLAY;
            PLAY:  if (beat_tick && step_count == SONG_LAST) state_next = FLUSH;
            FLUSH: if (beat_tick && flush_cnt == FLUSH_LAST) state_next = DONE;
            DONE:  if (bus.start) state_next = PLAY;
            default: state_next = IDLE;
        endcase
    end

    // Beat counter and step/flush counters. The beat counter wraps on the
    // last song pulse, so it already starts FLUSH at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt   <= '0;
            step_count <= '0;
            flush_cnt  <= '0;
        end else if (start_go) begin
            beat_cnt   <= '0;
            step_count <= '0;
            flush_cnt  <= '0;
        end else if (active && !bus.pause) begin
            beat_cnt <= beat_tick ? '0 : beat_cnt + 1'b1;
            if (beat_tick && state == PLAY) begin
                step_count <= step_count + 1'b1;
            end
            if (beat_tick && state == FLUSH) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // The ROM is fed the value the step address takes on this edge, so its
    // registered output always holds rom[step address] and only moves on a
    // start or a PLAY pulse edge.
    always_comb begin
        step_addr_next = step_count;
        if (start_go) begin
            step_addr_next = '0;
        end else if (beat_tick && state == PLAY) begin
            step_addr_next = step_count + 1'b1;
        end
    end

    step_rom #(
        .SONG_LEN (SONG_LEN),
        .AW       (CW),
        .SONG_INIT(SONG_INIT)
    ) u_rom (
        .clk (clk),
        .addr(step_addr_next),
        .data(rom_data)
    );

    // Column scan: free-running, independent of the FSM and of pause.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            col_en   <= COL_RESET;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            col_en   <= {col_en[2:0], col_en[3]};
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // FSM: outputs
    always_comb begin
        bus.stepEn    = beat_tick;
        bus.inputStep = (state == PLAY) ? rom_data : 4'b0000;
        bus.colEn     = col_en;
        bus.stepCount = step_count;
        bus.playing   = active;
        bus.songDone  = (state == DONE);
        bus.state     = state;
    end

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  localparam int BC = 4;
  localparam int SC = 3;
  localparam int SL = 4;
  localparam int FB = 8;

  localparam int P_IDLE  = 0;
  localparam int P_PLAY  = 1;
  localparam int P_FLUSH = 2;
  localparam int P_DONE  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  step_sequencer_if #(.SONG_LEN(SL)) bus ();

  // Song {1,2,4,8}: word i sits in nibble i.
  step_sequencer #(
    .BEAT_CYCLES(BC),
    .SCAN_CYCLES(SC),
    .SONG_LEN   (SL),
    .FLUSH_BEATS(FB),
    .SONG_INIT  (16'h8421)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [3:0] song [SL] = '{4'h1, 4'h2, 4'h4, 4'h8};

  // ---------------- reference model ----------------
  // A beat is BC unpaused active cycles; pulse k of a song carries song[k-1]
  // for k <= SL and blank afterwards; the song ends after SL+FB pulses.
  int m_phase = P_IDLE;
  int m_units = 0;
  int m_pulses = 0;
  int m_scan = 0;

  typedef struct {
    bit         chk;
    bit         pulse;
    bit         playing;
    bit         done;
    int         count;
    logic [3:0] col;
    bit         zero_step;
  } status_t;

  status_t    st_q[$];
  logic [19:0] exp_q[$];   // {cycle[15:0], inputStep}

  int vectors = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input bit st, input bit pa);
    status_t s;
    logic [3:0] stp;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.start = st;
    bus.pause = pa;
    s.chk       = 1'b1;
    s.playing   = (m_phase == P_PLAY) || (m_phase == P_FLUSH);
    s.done      = (m_phase == P_DONE);
    s.count     = (m_pulses > SL) ? SL : m_pulses;
    s.col       = 4'(1 << ((m_scan / SC) % 4));
    s.zero_step = (m_phase != P_PLAY);
    s.pulse     = 1'b0;
    if (s.playing && !pa) begin
      m_units++;
      if (m_units % BC == 0) begin
        m_pulses++;
        stp = (m_pulses <= SL) ? song[m_pulses-1] : 4'h0;
        s.pulse = 1'b1;
        exp_q.push_back({cyc[15:0], stp});
      end
    end
    st_q.push_back(s);
    m_scan++;
    if ((m_phase == P_IDLE || m_phase == P_DONE) && st) begin
      m_phase = P_PLAY;
      m_units = 0;
      m_pulses = 0;
    end else if (m_phase == P_PLAY && m_pulses == SL) begin
      m_phase = P_FLUSH;
    end else if (m_phase == P_FLUSH && m_pulses == SL + FB) begin
      m_phase = P_DONE;
    end
  endtask

  task automatic do_reset(input int n);
    status_t s;
    s.chk = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      st_q.push_back(s);
    end
    m_phase = P_IDLE;
    m_units = 0;
    m_pulses = 0;
    m_scan = 0;
  endtask

  task automatic run(input int n);
    repeat (n) apply(1'b0, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : mon
    status_t ms;
    logic [19:0] e;
    if (st_q.size() > 0) begin
      ms = st_q.pop_front();
      if (ms.chk) begin
        check("stepEn", 32'(bus.stepEn), 32'(ms.pulse));
        check("playing", 32'(bus.playing), 32'(ms.playing));
        check("songDone", 32'(bus.songDone), 32'(ms.done));
        check("stepCount", 32'(bus.stepCount), ms.count);
        check("colEn", 32'(bus.colEn), 32'(ms.col));
        if (ms.zero_step) check("inputStep_blank", 32'(bus.inputStep), 32'd0);
      end
    end
    if (bus.stepEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("stepEn_unexpected", 32'(bus.stepEn), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, 32'(e[19:4]));
        check("pulse_inputStep", 32'(bus.inputStep), 32'(e[3:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;

    // reset values and idle column scan
    do_reset(2);
    run(20);

    // full song
    apply(1'b1, 1'b0);
    run(52);

    // pause covering the second terminal count
    apply(1'b1, 1'b0);
    run(7);
    repeat (10) apply(1'b0, 1'b1);
    run(60);

    // pause rising exactly on the terminal-count cycle
    apply(1'b1, 1'b0);
    run(3);
    apply(1'b0, 1'b1);
    run(55);

    // start ignored while playing, then restart from DONE
    apply(1'b1, 1'b0);
    run(5);
    repeat (3) apply(1'b1, 1'b0);
    run(50);
    apply(1'b1, 1'b0);
    run(52);

    // reset between pulses 2 and 3, idle, then a fresh song
    apply(1'b1, 1'b0);
    run(10);
    do_reset(1);
    run(10);
    apply(1'b1, 1'b0);
    run(52);

    // randomized pause and start traffic
    for (int r = 0; r < 3; r++) begin
      apply(1'b1, 1'b0);
      repeat (150) apply($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end
    run(80);

    @(negedge clk);
    @(negedge clk);
    check("pulses_outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
